hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Stall/flush controller for the 5-stage RV32I pipeline. It is the counterpart to the forwarding unit.
- Forwarding resolves RAW dependences by bypassing data. This block handles what forwarding cannot: load-use hazards (stall and bubble insertion), taken branches/jumps resolved in EX (squash), and data-memory wait states (freeze).
- Outputs drive the enable and clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard. Legal range 1..3.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- instr_id  in  32  instruction in ID.
- instr_ex  in  32  instruction in EX.
- brtaken_ex  in  1  branch taken or jump in EX.
- mem_busy  in  1  data memory not ready this cycle.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold IF/ID.
- stall_ex  out  1  hold ID/EX.
- stall_mem  out  1  hold EX/MEM.
- flush_id  out  1  clear IF/ID to NOP (0x00000013).
- flush_ex  out  1  clear ID/EX to NOP.
- stall_cnt  out  CNT_W  cycles with stall_if=1.
- flush_cnt  out  CNT_W  cycles with flush_id=1.

Behaviour:
- Decode of instr_ex:
  - Load: instr_ex[6:2]==5'b00000.
  - rd_ex = instr_ex[11:7].
- Decode of instr_id:
  - rs1 = [19:15], rs2 = [24:20].
  - rs1 used unless opcode[6:2] is 01101 (LUI), 00101 (AUIPC) or 11011 (JAL).
  - rs2 used only for 01100 (R-type), 01000 (store) and 11000 (branch).
- lu_haz = load & rd_ex!=0 & ((rs1 used & rs1==rd_ex) | (rs2 used & rs2==rd_ex)).
- State machine:
  - States RUN and LU_STALL. Down-counter cnt, 2 bits.
  - Reset: state=RUN, cnt=0, stall_cnt=0, flush_cnt=0.
  - While rst_n=0, all stall_*/flush_* outputs are forced 0.
- Control outputs are combinational from state and inputs, evaluated in strict priority:
  1. mem_busy=1 (any state):
     - stall_if=stall_id=stall_ex=stall_mem=1, all flushes=0.
     - state and cnt hold.
     - Takes priority even over brtaken_ex; the branch is seen again next cycle because EX is held.
  2. state=LU_STALL:
     - stall_if=stall_id=1, flush_ex=1.
     - cnt decrements each cycle; return to RUN on the edge where cnt==1.
  3. RUN with brtaken_ex=1:
     - flush_id=flush_ex=1, no stalls.
     - lu_haz is ignored, because the ID instruction is being squashed.
  4. RUN with lu_haz=1:
     - stall_if=stall_id=1, flush_ex=1.
     - If LOAD_STALL_CYCLES>1: go to LU_STALL with cnt=LOAD_STALL_CYCLES-1.
     - Otherwise stay in RUN; the load has advanced to MEM, so lu_haz clears by itself.
  5. Otherwise: all outputs 0.
- A load to x0 never stalls.
- A bubble (NOP) in EX never stalls.
- Total stall length for one hazard is exactly LOAD_STALL_CYCLES cycles, plus any mem_busy cycles interleaved.
- Counters:
  - stall_cnt increments on each edge where stall_if=1 (this includes mem_busy cycles).
  - flush_cnt increments on each edge where flush_id=1.
  - Both saturate at all-ones and do not wrap.
- Reset asserted mid-LU_STALL: next state is RUN, cnt=0, counters=0.
- Hazard detection latency: 0 cycles (combinational). Stall decision takes effect at the next rising edge.

Test Plan:
- lw x5,0(x1) (0x0000A283) in EX, add x6,x5,x1 (0x00128333) in ID, LOAD_STALL_CYCLES=1 -> one cycle of stall_if=stall_id=flush_ex=1, then all 0; stall_cnt=1.
- Same pair with LOAD_STALL_CYCLES=3 -> three consecutive stall cycles (RUN→LU_STALL→LU_STALL→RUN); stall_cnt=3.
- Load-use pairs that must NOT stall (all outputs 0, counters unchanged):
  - lw x0 (0x0000A003) then add reading x0.
  - lw x5 then lui x6,0x28 (0x00028337; rs1 field =5 but unused).
- jal x1,4 (0x004000EF) in EX with brtaken_ex=1 -> flush_id=flush_ex=1 for one cycle, no stalls; flush_cnt=1.
- mem_busy=1 for 2 cycles during second cycle of a 3-cycle LU_STALL -> all four stalls=1 for 2 cycles, flush_ex=0; after release, remaining 2 LU_STALL cycles complete; stall_cnt=5.
- Other boundary cases:
  - rst_n=0 mid-LU_STALL -> outputs 0 that cycle; after release state RUN, counters 0.
  - Counter preset near max with CNT_W=4 -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: load-use bubbles,
// squash on taken branches/jumps resolved in EX, and freeze on data-memory wait.
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_id,
  input  logic [31:0]      instr_ex,
  input  logic             brtaken_ex,
  input  logic             mem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic       ST_RUN      = 1'b0;
  localparam logic       ST_LU_STALL = 1'b1;
  localparam logic [1:0] EXTRA_STALL = 2'(LOAD_STALL_CYCLES - 1);

  logic             state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       ex_is_load;
  logic [4:0] rd_ex, rs1_id, rs2_id, op_id;
  logic       rs1_used, rs2_used, lu_haz;

  logic unused_bits;
  assign unused_bits = ^{instr_id[31:25], instr_id[14:7], instr_id[1:0],
                         instr_ex[31:12], instr_ex[1:0]};

  assign ex_is_load = (instr_ex[6:2] == 5'b00000);
  assign rd_ex      = instr_ex[11:7];
  assign op_id      = instr_id[6:2];
  assign rs1_id     = instr_id[19:15];
  assign rs2_id     = instr_id[24:20];
  assign rs1_used   = !((op_id == 5'b01101) || (op_id == 5'b00101) || (op_id == 5'b11011));
  assign rs2_used   = (op_id == 5'b01100) || (op_id == 5'b01000) || (op_id == 5'b11000);

  // x0 as destination never creates a dependence, so a load to x0 never stalls.
  assign lu_haz = ex_is_load && (rd_ex != 5'd0) &&
                  ((rs1_used && (rs1_id == rd_ex)) || (rs2_used && (rs2_id == rd_ex)));

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    if (!rst_n) begin
      state_d = ST_RUN;
      cnt_d   = 2'd0;
    end else if (mem_busy) begin
      // Freeze everything; a pending branch in EX is re-seen once memory is ready.
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
    end else if (state_q == ST_LU_STALL) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
      cnt_d    = cnt_q - 2'd1;
      if (cnt_q == 2'd1) state_d = ST_RUN;
    end else if (brtaken_ex) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (lu_haz) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        state_d = ST_LU_STALL;
        cnt_d   = EXTRA_STALL;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_if && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_id && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1-cycle/4-bit counters and 3-cycle/32-bit
// counters) share stimulus and are compared against a bubble-budget reference model.
module tb_hazard_ctrl;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] LW5  = 32'h0000_A283;
  localparam logic [31:0] LW0  = 32'h0000_A003;
  localparam logic [31:0] ADD  = 32'h0012_8333;
  localparam logic [31:0] ADD0 = 32'h0000_0333;
  localparam logic [31:0] LUI  = 32'h0002_8337;
  localparam logic [31:0] JAL  = 32'h0040_00EF;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n      = 1'b0;
  logic [31:0] instr_id   = NOP;
  logic [31:0] instr_ex   = NOP;
  logic        brtaken_ex = 1'b0;
  logic        mem_busy   = 1'b0;

  logic        a_sif, a_sid, a_sex, a_smem, a_fid, a_fex;
  logic        b_sif, b_sid, b_sex, b_smem, b_fid, b_fex;
  logic [3:0]  a_scnt, a_fcnt;
  logic [31:0] b_scnt, b_fcnt;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .instr_id(instr_id), .instr_ex(instr_ex),
    .brtaken_ex(brtaken_ex), .mem_busy(mem_busy),
    .stall_if(a_sif), .stall_id(a_sid), .stall_ex(a_sex), .stall_mem(a_smem),
    .flush_id(a_fid), .flush_ex(a_fex), .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .instr_id(instr_id), .instr_ex(instr_ex),
    .brtaken_ex(brtaken_ex), .mem_busy(mem_busy),
    .stall_if(b_sif), .stall_id(b_sid), .stall_ex(b_sex), .stall_mem(b_smem),
    .flush_id(b_fid), .flush_ex(b_fex), .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

  // scoreboard
  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: remaining bubble budget and saturating event counts
  int      lsc[2]  = '{1, 3};
  longint  cmax[2] = '{15, 64'hFFFF_FFFF};
  int      rem[2];
  longint  scnt[2], fcnt[2];

  function automatic bit ref_haz(input logic [31:0] ex, input logic [31:0] id);
    int op, rd, r1, r2;
    bit u1, u2;
    op = int'(id[6:2]);
    rd = int'(ex[11:7]);
    r1 = int'(id[19:15]);
    r2 = int'(id[24:20]);
    u1 = !(op == 'h0D || op == 'h05 || op == 'h1B);
    u2 = (op == 'h0C || op == 'h08 || op == 'h18);
    return (ex[6:2] == 5'd0) && rd != 0 && ((u1 && r1 == rd) || (u2 && r2 == rd));
  endfunction

  // order: stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex
  function automatic logic [5:0] ref_outs(input int k);
    if (!rst_n)               return 6'b000000;
    if (mem_busy)             return 6'b111100;
    if (rem[k] > 0)           return 6'b110001;
    if (brtaken_ex)           return 6'b000011;
    if (ref_haz(instr_ex, instr_id)) return 6'b110001;
    return 6'b000000;
  endfunction

  task automatic model_edge();
    logic [5:0] o;
    for (int k = 0; k < 2; k++) begin
      o = ref_outs(k);
      if (!rst_n) begin
        rem[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      end else begin
        if (o[5] && scnt[k] < cmax[k]) scnt[k]++;
        if (o[1] && fcnt[k] < cmax[k]) fcnt[k]++;
        if (mem_busy) ;
        else if (rem[k] > 0) rem[k]--;
        else if (brtaken_ex) ;
        else if (ref_haz(instr_ex, instr_id)) rem[k] = lsc[k] - 1;
      end
    end
  endtask

  // driver: apply one cycle of inputs, check mid-cycle, advance model at the edge
  task automatic step(input logic rst, input logic [31:0] id, input logic [31:0] ex,
                      input logic br, input logic busy);
    rst_n = rst; instr_id = id; instr_ex = ex; brtaken_ex = br; mem_busy = busy;
    @(negedge clk);
    check_eq("a_ctrl",  32'({a_sif, a_sid, a_sex, a_smem, a_fid, a_fex}), 32'(ref_outs(0)));
    check_eq("b_ctrl",  32'({b_sif, b_sid, b_sex, b_smem, b_fid, b_fex}), 32'(ref_outs(1)));
    check_eq("a_stall_cnt", 32'(a_scnt), 32'(scnt[0]));
    check_eq("a_flush_cnt", 32'(a_fcnt), 32'(fcnt[0]));
    check_eq("b_stall_cnt", b_scnt, 32'(scnt[1]));
    check_eq("b_flush_cnt", b_fcnt, 32'(fcnt[1]));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, NOP, NOP, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, NOP, NOP, 1'b0, 1'b0);
    step(1'b0, NOP, NOP, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr(input bit for_ex);
    logic [4:0]  ops[8] = '{5'b00000, 5'b00000, 5'b01100, 5'b01000,
                            5'b11000, 5'b01101, 5'b00101, 5'b11011};
    logic [31:0] x;
    x = $urandom;
    x[1:0]   = 2'b11;
    x[6:2]   = ops[$urandom_range(0, 7)];
    x[11:7]  = 5'($urandom_range(0, 7));
    x[19:15] = 5'($urandom_range(0, 7));
    x[24:20] = 5'($urandom_range(0, 7));
    if (for_ex && $urandom_range(0, 5) == 0) x = NOP;
    return x;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin rem[k] = 0; scnt[k] = 0; fcnt[k] = 0; end
    #1;
    do_reset();

    // basic load-use pair
    step(1'b1, ADD, LW5, 1'b0, 1'b0);
    idle(4);
    check_eq("lu_stall_cnt_a", 32'(a_scnt), 32'd1);
    check_eq("lu_stall_cnt_b", b_scnt, 32'd3);

    // non-stalling pairs
    do_reset();
    step(1'b1, ADD0, LW0, 1'b0, 1'b0);
    step(1'b1, LUI,  LW5, 1'b0, 1'b0);
    idle(1);
    check_eq("no_stall_cnt", b_scnt, 32'd0);

    // taken jump squashes, hazard in ID ignored
    step(1'b1, ADD, JAL, 1'b1, 1'b0);
    idle(1);
    check_eq("jal_flush_cnt", b_fcnt, 32'd1);

    // memory wait in the middle of a 3-cycle load-use stall
    do_reset();
    step(1'b1, ADD, LW5, 1'b0, 1'b0);
    step(1'b1, NOP, NOP, 1'b0, 1'b0);
    step(1'b1, NOP, NOP, 1'b0, 1'b1);
    step(1'b1, NOP, NOP, 1'b0, 1'b1);
    idle(4);
    check_eq("busy_stall_cnt", b_scnt, 32'd5);

    // reset in the middle of a stall
    do_reset();
    step(1'b1, ADD, LW5, 1'b0, 1'b0);
    step(1'b0, NOP, NOP, 1'b0, 1'b0);
    idle(3);
    check_eq("rst_mid_stall_cnt", b_scnt, 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) != 0), rand_instr(1'b0), rand_instr(1'b1),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
    end

    // long memory wait saturates the 4-bit stall counter
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, NOP, NOP, 1'b0, 1'b1);
    idle(1);
    check_eq("sat_stall_cnt", 32'(a_scnt), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
